alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational execute-stage ALU. Same operation set: add/sub/cmp/mul/div/mod/shifts/logic/mov/ld/st address add.
- Adds a valid/ready handshake on both sides, a registered result, an iterative divider, and a properly registered flag set.
- Sits between the register-read/forwarding stage and the memory stage, and stalls the pipeline through in_ready while a divide is in progress.

Parameters:
- WIDTH, 32: operand and result width; must be ≥ 8 and a power of two.
- TAG_W, 5: width of the sideband tag carried from input to output (destination register index).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset. Synchronous and active-low.
- in_valid, input, 1: operation presented.
- in_ready, output, 1: block accepts the operation this cycle.
- in_op, input, 4: opcode, encoded as alu_mc_pkg::op_e.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B (register or immediate).
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: result held valid.
- out_ready, input, 1: consumer takes the result.
- out_result, output, WIDTH: registered result.
- out_tag, output, TAG_W: tag of the operation that produced out_result.
- flags, output, 4: bit0 E, bit1 GT, bit2 N, bit3 DZ.
- busy, output, 1: high while state is DIV.

Behaviour:
- Opcodes:
  - ADD=0, SUB=1, CMP=2, MUL=3, DIV=4, MOD=5, LSL=6, LSR=7, ASR=8, OR=9, AND=10, NOT=11, MOV=12, LD=13, ST=14.
  - 15 is illegal: produces result 0, flags unchanged.
- Reset (rst_n=0 at an edge):
  - State → IDLE.
  - out_valid=0, out_result=0, out_tag=0, flags=0, busy=0.
  - Any divide in progress is abandoned with no output.
- Acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An op is accepted when in_valid && in_ready.
  - in_ready is combinational from out_ready. No other input-to-output combinational path.
- Single-cycle ops (everything except DIV/MOD):
  - Result, tag and flags are loaded at the accept edge.
  - out_valid=1 from the next cycle, so latency is 1.
  - Back-to-back throughput is 1/cycle while out_ready=1.
- Multi-cycle ops (DIV/MOD):
  - At accept, state → DIV and the divider is loaded.
  - Restoring divider retires one quotient bit per cycle for WIDTH cycles.
  - On the last iteration edge the result is loaded, out_valid=1 and state → IDLE.
  - Latency WIDTH+1 cycles from accept to out_valid. in_ready=0 throughout DIV.
- Output hold: out_valid, out_result and out_tag stay stable until out_valid && out_ready. If no new op is accepted at that edge, out_valid drops.
- Arithmetic (all results WIDTH bits, truncated mod 2^WIDTH):
  - ADD, LD, ST: A+B.
  - SUB, CMP: A−B.
  - MUL: low WIDTH bits of A*B.
  - DIV, MOD: unsigned.
  - Shifts use in_b[$clog2(WIDTH)-1:0] only.
  - ASR is a signed shift: the sign bit of A is replicated.
  - NOT: ~A. MOV: B.
- Divide by zero:
  - DIV returns all-ones; MOD returns A.
  - Still takes WIDTH+1 cycles.
- Flags:
  - E, GT and N update only when a CMP is accepted:
    - E = (A==B).
    - GT = signed(A) > signed(B).
    - N = MSB of A−B.
  - They hold their value across all other ops.
  - DZ updates on every DIV/MOD completion: 1 if B==0, else 0.
- Simultaneous events:
  - A drain and a new accept on the same edge load the new result with out_valid staying 1.
  - Reset takes priority over everything.

Decomposition:
- alu_mc_pkg holds:
  - op_e enum (4-bit).
  - state_e {IDLE, DIV}.
  - Flag bit-index constants FLG_E=0, FLG_GT=1, FLG_N=2, FLG_DZ=3.
- Sub-module alu_mc_divider (WIDTH):
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done pulse.
  - Handles divide-by-zero internally.
- Top level holds the single-cycle datapath, FSM, output register and flags.

Test Plan:
1. Reset, then ADD A=7, B=5, tag=3, out_ready=1 → out_valid one cycle after accept, out_result=12, out_tag=3, flags=0.
2. CMP A=−2, B=5, then ADD 1+1 → after the CMP, flags=4'b0100 (N=1, GT=0, E=0); flags unchanged after the ADD; CMP 9,9 → E=1, N=0.
3. DIV 100/7 with tag=9 → in_ready=0 and busy=1 for 32 cycles; out_result=14 at accept+33. MOD 100%7 → 2; DZ=0.
4. DIV 55/0 → out_result=32'hFFFFFFFF, DZ=1. MOD 55/0 → 55. A following DIV 8/2 → 4 and DZ=0.
5. ASR A=32'h80000010, B=36 (low 5 bits = 4) → 32'hF8000001. LSR with the same operands → 32'h08000001.
6. Backpressure plus mid-divide reset:
   - Hold out_ready=0 after ADD 1+2 → in_ready=0 and out_result stays 3 for 5 cycles; raising out_ready with in_valid high drains 3 and loads the next result on the same edge.
   - Separately, assert rst_n=0 during cycle 10 of a DIV → out_valid=0, state IDLE, no stale result appears.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle execute-stage ALU.
// Opcode encoding matches the combinational ALU it replaces.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpCmp = 4'd2,
        OpMul = 4'd3,
        OpDiv = 4'd4,
        OpMod = 4'd5,
        OpLsl = 4'd6,
        OpLsr = 4'd7,
        OpAsr = 4'd8,
        OpOr  = 4'd9,
        OpAnd = 4'd10,
        OpNot = 4'd11,
        OpMov = 4'd12,
        OpLd  = 4'd13,
        OpSt  = 4'd14,
        OpIll = 4'd15
    } op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StDiv  = 1'b1
    } state_e;

    localparam int unsigned FLG_E  = 0;
    localparam int unsigned FLG_GT = 1;
    localparam int unsigned FLG_N  = 2;
    localparam int unsigned FLG_DZ = 3;
    localparam int unsigned NumFlags = 4;

    function automatic logic is_div_op(input op_e op);
        return (op == OpDiv) || (op == OpMod);
    endfunction

endpackage

// File: rtl/alu_mc_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
// quotient_o/remainder_o are valid while done_o is high (the final iteration cycle).
module alu_mc_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             active_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_q;
    logic             dz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            dz_q     <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= dividend_i;
            dvs_q    <= divisor_i;
            dvd_q    <= dividend_i;
            dz_q     <= (divisor_i == '0);
        end else if (active_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
                active_q <= 1'b0;
            end
        end
    end

    // Divide-by-zero still runs the full iteration count; only the result is overridden.
    assign done_o      = active_q && (cnt_q == CntW'(WIDTH - 1));
    assign quotient_o  = dz_q ? '1 : quo_d;
    assign remainder_o = dz_q ? dvd_q : rem_d;
    assign div_zero_o  = dz_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes, registered result and flags.
// DIV/MOD run on an iterative divider and hold off new operations while in progress.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_op_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [3:0]       flags_o,
    output logic             busy_o
);

    localparam int unsigned ShW = $clog2(WIDTH);

    state_e              state_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_result_q;
    logic [TAG_W-1:0]    out_tag_q;
    logic [NumFlags-1:0] flags_q;
    logic [TAG_W-1:0]    pend_tag_q;
    logic                pend_mod_q;

    op_e              op;
    logic             accept;
    logic [ShW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] alu_res;

    logic             div_start;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_dz;
    logic             div_done;

    assign op         = op_e'(in_op_i);
    assign in_ready_o = (state_q == StIdle) && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign div_start  = accept && is_div_op(op);

    assign shamt = in_b_i[ShW-1:0];
    assign sum   = in_a_i + in_b_i;
    assign diff  = in_a_i - in_b_i;
    assign prod  = in_a_i * in_b_i;

    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd, OpLd, OpSt: alu_res = sum;
            OpSub, OpCmp:      alu_res = diff;
            OpMul:             alu_res = prod;
            OpLsl:             alu_res = in_a_i << shamt;
            OpLsr:             alu_res = in_a_i >> shamt;
            OpAsr:             alu_res = WIDTH'($signed(in_a_i) >>> shamt);
            OpOr:              alu_res = in_a_i | in_b_i;
            OpAnd:             alu_res = in_a_i & in_b_i;
            OpNot:             alu_res = ~in_a_i;
            OpMov:             alu_res = in_b_i;
            default:           alu_res = '0;
        endcase
    end

    alu_mc_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (div_start),
        .dividend_i  (in_a_i),
        .divisor_i   (in_b_i),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .div_zero_o  (div_dz),
        .done_o      (div_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            flags_q      <= '0;
            pend_tag_q   <= '0;
            pend_mod_q   <= 1'b0;
        end else begin
            // A new load below overrides this drain when both happen on one edge.
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_div_op(op)) begin
                            state_q    <= StDiv;
                            pend_tag_q <= in_tag_i;
                            pend_mod_q <= (op == OpMod);
                        end else begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= alu_res;
                            out_tag_q    <= in_tag_i;
                            if (op == OpCmp) begin
                                flags_q[FLG_E]  <= (in_a_i == in_b_i);
                                flags_q[FLG_GT] <= ($signed(in_a_i) > $signed(in_b_i));
                                flags_q[FLG_N]  <= diff[WIDTH-1];
                            end
                        end
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        state_q         <= StIdle;
                        out_valid_q     <= 1'b1;
                        out_result_q    <= pend_mod_q ? div_rem : div_quo;
                        out_tag_q       <= pend_tag_q;
                        flags_q[FLG_DZ] <= div_dz;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_tag_o    = out_tag_q;
    assign flags_o      = flags_q;
    assign busy_o       = (state_q == StDiv);

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a scoreboard queue holds predicted results, which a
// monitor compares whenever the DUT hands off an output.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned T = 5;

    typedef struct packed {
        logic [W-1:0] res;
        logic [T-1:0] tag;
        logic [3:0]   flg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [T-1:0] in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [T-1:0] out_tag;
    logic [3:0]   flags;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] mflags = 4'b0;

    always #5 clk = ~clk;

    alu_mc #(
        .WIDTH (W),
        .TAG_W (T)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_op_i      (in_op),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .in_tag_i     (in_tag),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_result_o (out_result),
        .out_tag_o    (out_tag),
        .flags_o      (flags),
        .busy_o       (busy)
    );

    task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference model: predicts result and the flag state once this op completes.
    task automatic predict(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [T-1:0] tag, output exp_t e);
        logic [W-1:0] r;
        logic [4:0]   sh;
        sh = b[4:0];
        case (op)
            4'd0, 4'd13, 4'd14: r = a + b;
            4'd1: r = a - b;
            4'd2: begin
                r = a - b;
                mflags[0] = (a == b);
                mflags[1] = ($signed(a) > $signed(b));
                mflags[2] = r[W-1];
            end
            4'd3: r = a * b;
            4'd4: begin
                r = (b == 0) ? '1 : a / b;
                mflags[3] = (b == 0);
            end
            4'd5: begin
                r = (b == 0) ? a : a % b;
                mflags[3] = (b == 0);
            end
            4'd6:  r = a << sh;
            4'd7:  r = a >> sh;
            4'd8:  r = $signed(a) >>> sh;
            4'd9:  r = a | b;
            4'd10: r = a & b;
            4'd11: r = ~a;
            4'd12: r = b;
            default: r = '0;
        endcase
        e.res = r;
        e.tag = tag;
        e.flg = mflags;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tag, input bit expect_out);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept", in_ready, 1);
        if (in_ready) begin
            predict(op, a, b, tag, e);
            if (expect_out) sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, out_valid, 1);
    endtask

    // Monitor: any handed-off output must match the oldest prediction.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=%h expected=none", out_result);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_result", out_result, mon_e.res);
                check("sb_tag", W'(out_tag), W'(mon_e.tag));
                check("sb_flags", W'(flags), W'(mon_e.flg));
            end
        end
    end

    initial begin
        bit seen;
        int n;
        exp_t e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", W'(out_tag), 0);
        check("rst_flags", W'(flags), 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd0, 7, 5, 3, 1);
        check("add_latency", out_valid, 1);
        check("add_result", out_result, 12);
        check("add_tag", W'(out_tag), 3);

        issue(4'd2, 32'hFFFF_FFFE, 5, 1, 1);
        check("cmp_neg_flags", W'(flags), W'(4'b0100));
        issue(4'd0, 1, 1, 2, 1);
        check("add_keeps_flags", W'(flags), W'(4'b0100));
        issue(4'd2, 9, 9, 4, 1);
        check("cmp_eq_flags", W'(flags), W'(4'b0001));

        issue(4'd4, 100, 7, 9, 1);
        for (int i = 0; i < 32; i++) begin
            check("div_busy", busy, 1);
            check("div_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        check("div_latency", out_valid, 1);
        check("div_result", out_result, 14);
        check("div_tag", W'(out_tag), 9);
        issue(4'd5, 100, 7, 10, 1);
        wait_out("mod_done");
        check("mod_result", out_result, 2);
        check("mod_dz", W'(flags[3]), 0);

        issue(4'd4, 55, 0, 11, 1);
        wait_out("divz_done");
        check("divz_result", out_result, 32'hFFFF_FFFF);
        check("divz_dz", W'(flags[3]), 1);
        issue(4'd5, 55, 0, 12, 1);
        wait_out("modz_done");
        check("modz_result", out_result, 55);
        issue(4'd4, 8, 2, 13, 1);
        wait_out("div8_done");
        check("div8_result", out_result, 4);
        check("div8_dz", W'(flags[3]), 0);

        issue(4'd8, 32'h8000_0010, 36, 14, 1);
        check("asr_result", out_result, 32'hF800_0001);
        issue(4'd7, 32'h8000_0010, 36, 15, 1);
        check("lsr_result", out_result, 32'h0800_0001);
        issue(4'd6, 32'h0000_00F1, 32'h0000_0104, 16, 1);
        issue(4'd3, 32'h0001_2345, 32'h0000_1000, 17, 1);
        issue(4'd1, 3, 5, 18, 1);
        issue(4'd9, 32'hF0F0_0000, 32'h0000_0F0F, 19, 1);
        issue(4'd10, 32'hFF00_FF00, 32'h0FF0_0FF0, 20, 1);
        issue(4'd11, 32'h1234_5678, 0, 21, 1);
        issue(4'd12, 0, 32'hCAFE_F00D, 22, 1);
        issue(4'd13, 32'h1000, 32'h24, 23, 1);
        issue(4'd14, 32'h2000, 32'hFFFF_FFFC, 24, 1);
        issue(4'd2, 5, 32'hFFFF_FFFF, 25, 1);
        issue(4'd15, 32'hDEAD_BEEF, 1, 26, 1);
        check("illegal_result", out_result, 0);
        check("illegal_flags", W'(flags), W'(mflags));

        // Backpressure: output held, then drain and reload on one edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        issue(4'd0, 1, 2, 5, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_result", out_result, 3);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 4'd0;
        in_a      = 4;
        in_b      = 5;
        in_tag    = 7;
        #1;
        check("bp_same_edge_ready", in_ready, 1);
        predict(4'd0, 4, 5, 7, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_reload_valid", out_valid, 1);
        check("bp_reload_result", out_result, 9);
        check("bp_reload_tag", W'(out_tag), 7);

        // Reset partway through a divide: nothing may emerge afterwards.
        repeat (3) @(posedge clk);
        issue(4'd4, 1000, 3, 8, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", out_result, 0);
        check("mid_rst_flags", W'(flags), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mflags = 4'b0;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        check("no_stale_output", seen, 0);
        check("post_rst_idle", in_ready, 1);
        issue(4'd0, 20, 22, 30, 1);
        check("post_rst_add", out_result, 42);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
